// File: rtl/adpcm_chan_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_chan_sched_if
// Purpose  : Frame-sync, config-table, datapath handshake and status bundle
//            between the channel scheduler and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface adpcm_chan_sched_if #(
    parameter int CH_W = 5
);
    logic            fs;
    logic            cfg_we;
    logic [CH_W-1:0] cfg_addr;
    logic [4:0]      cfg_wdata;
    logic            clr_err;
    logic            done;
    logic            start;
    logic [CH_W-1:0] chan;
    logic [1:0]      rate;
    logic            law;
    logic            dec;
    logic            busy;
    logic            overrun;
    logic            timeout;

    // Scheduler side: drives the datapath request and status
    modport master (
        input  fs, cfg_we, cfg_addr, cfg_wdata, clr_err, done,
        output start, chan, rate, law, dec, busy, overrun, timeout
    );

    // Environment side: frame timing, config host and ADPCM datapath
    modport slave (
        output fs, cfg_we, cfg_addr, cfg_wdata, clr_err, done,
        input  start, chan, rate, law, dec, busy, overrun, timeout
    );
endinterface
`default_nettype wire

// File: rtl/adpcm_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_chan_sched
// Purpose  : Per-frame scheduler that time-shares one ADPCM datapath across
//            NCH TDM channels, one start/done transaction per enabled channel,
//            with sticky overrun and timeout fault flags.
// Options  : ADPCM_SCHED_STATS_EN adds frame_cycles (cycles per last frame).
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_chan_sched #(
    parameter int NCH     = 32,
    parameter int CH_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          scan_in0,
    input  wire logic          scan_in1,
    input  wire logic          scan_in2,
    input  wire logic          scan_in3,
    input  wire logic          scan_in4,
    input  wire logic          scan_enable,
    input  wire logic          test_mode,
    output logic               scan_out0,
    output logic               scan_out1,
    output logic               scan_out2,
    output logic               scan_out3,
    output logic               scan_out4,
`ifdef ADPCM_SCHED_STATS_EN
    output logic [15:0]        frame_cycles,
`endif
    adpcm_chan_sched_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [CH_W-1:0] c_last_ptr = CH_W'(NCH - 1);
    localparam logic [7:0]      c_tmo_last = 8'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_ptr_nxt;
    logic [7:0]      r_tmo_cnt;
    logic [7:0]      w_tmo_cnt_nxt;
    logic            w_latch;
    logic            w_tmo_hit;
    logic            w_ovr_set;

    // Table entry layout: {en, dec, law, rate[1:0]}
    logic [4:0]      r_cfg [NCH];
    logic [4:0]      w_cur_cfg;

    logic [CH_W-1:0] r_chan;
    logic [1:0]      r_rate;
    logic            r_law;
    logic            r_dec;
    logic            r_overrun;
    logic            r_timeout;

    assign w_cur_cfg = r_cfg[r_ptr];
    // fs is only accepted in IDLE; anything else (including the cycle the
    // walk finishes) is an overrun and the pulse is dropped.
    assign w_ovr_set = bus.fs & (r_state != IDLE);

    // Next-state, pointer and wait-counter decode
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_latch       = 1'b0;
        w_tmo_hit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fs) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (w_cur_cfg[4]) begin
                    w_latch     = 1'b1;
                    w_state_nxt = START;
                end else if (r_ptr == c_last_ptr) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + CH_W'(1);
                end
            end
            START: begin
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                // done wins over a timeout landing on the same cycle
                if (bus.done || (r_tmo_cnt == c_tmo_last)) begin
                    w_tmo_hit = ~bus.done;
                    if (r_ptr == c_last_ptr) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_state_nxt = SCAN;
                        w_ptr_nxt   = r_ptr + CH_W'(1);
                    end
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // State, channel pointer and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // Channel configuration table, writable at any time
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            r_cfg[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Snapshot of the active channel's settings, frozen for the whole transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chan <= '0;
            r_rate <= '0;
            r_law  <= 1'b0;
            r_dec  <= 1'b0;
        end else if (w_latch) begin
            r_chan <= r_ptr;
            r_dec  <= w_cur_cfg[3];
            r_law  <= w_cur_cfg[2];
            r_rate <= w_cur_cfg[1:0];
        end
    end

    // Sticky fault flags; a new fault beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_ovr_set)        r_overrun <= 1'b1;
            else if (bus.clr_err) r_overrun <= 1'b0;
            if (w_tmo_hit)        r_timeout <= 1'b1;
            else if (bus.clr_err) r_timeout <= 1'b0;
        end
    end

    assign bus.start   = (r_state == START);
    assign bus.busy    = (r_state != IDLE);
    assign bus.chan    = r_chan;
    assign bus.rate    = r_rate;
    assign bus.law     = r_law;
    assign bus.dec     = r_dec;
    assign bus.overrun = r_overrun;
    assign bus.timeout = r_timeout;

`ifdef ADPCM_SCHED_STATS_EN
    logic [15:0] r_frame_run;
    logic [15:0] r_frame_cycles;
    logic [15:0] w_run_inc;

    assign w_run_inc = (r_frame_run == 16'hFFFF) ? r_frame_run : r_frame_run + 16'd1;

    // Count busy cycles of the current frame, publish the total on return to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_run    <= '0;
            r_frame_cycles <= '0;
        end else if (r_state == IDLE) begin
            if (w_state_nxt == SCAN) r_frame_run <= '0;
        end else begin
            r_frame_run <= w_run_inc;
            if (w_state_nxt == IDLE) r_frame_cycles <= w_run_inc;
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

    // Chains are stitched at scan insertion; the functional path never sees
    // these, and they stay quiet outside shift in test mode.
    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule
`default_nettype wire

// File: tb/tb_adpcm_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpcm_chan_sched
// Purpose  : Self-checking bench for adpcm_chan_sched: directed scenarios with
//            literal expectations plus a randomized run against a
//            visit-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpcm_chan_sched;

    localparam int NCH     = 32;
    localparam int CH_W    = 5;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset;
    logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    adpcm_chan_sched_if #(.CH_W(CH_W)) ifc ();

    adpcm_chan_sched #(.NCH(NCH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (1'b0),
        .scan_in1    (1'b0),
        .scan_in2    (1'b0),
        .scan_in3    (1'b0),
        .scan_in4    (1'b0),
        .scan_enable (1'b0),
        .test_mode   (1'b0),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4),
        .bus         (ifc)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: answers each start after a programmable delay
    bit   dp_auto  = 1'b0;
    bit   dp_rand  = 1'b0;
    int   dp_delay = 1;
    int   dp_cnt   = 0;
    logic dp_done  = 1'b0;
    logic tb_done  = 1'b0;

    assign ifc.done = dp_done | tb_done;

    always @(negedge clk) begin
        if (dp_auto && ifc.start)
            dp_cnt <= dp_rand ? (($urandom % 40 == 0) ? 300 : int'($urandom_range(1, 5))) : dp_delay;
        else if (dp_cnt > 0)
            dp_cnt <= dp_cnt - 1;
        dp_done <= (dp_cnt == 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a walk of channel visits; visit cycle v=0 is the look-up,
    // v=1 the request cycle, v>=2 the (v-1)th cycle spent waiting for done.
    bit       m_active;
    int       m_ch;
    int       m_v;
    bit [4:0] m_cfg [NCH];
    bit [4:0] m_chan;
    bit [1:0] m_rate;
    bit       m_law, m_dec, m_ovr, m_tmo;

    always @(posedge clk) begin : ref_model
        bit       act, ovr_set, tmo_set, adv;
        int       ch, v;
        bit [4:0] e;
        act = m_active; ch = m_ch; v = m_v;
        ovr_set = 1'b0; tmo_set = 1'b0; adv = 1'b0;
        if (reset) begin
            m_active <= 1'b0; m_ch <= 0; m_v <= 0;
            m_chan <= '0; m_rate <= '0; m_law <= 1'b0; m_dec <= 1'b0;
            m_ovr <= 1'b0; m_tmo <= 1'b0;
            for (int k = 0; k < NCH; k++) m_cfg[k] <= '0;
        end else begin
            ovr_set = ifc.fs && act;
            if (!act) begin
                if (ifc.fs) begin act = 1'b1; ch = 0; v = 0; end
            end else if (v == 0) begin
                e = m_cfg[ch];
                if (e[4]) begin
                    m_chan <= 5'(ch); m_dec <= e[3]; m_law <= e[2]; m_rate <= e[1:0];
                    v = 1;
                end else adv = 1'b1;
            end else if (v == 1) begin
                v = 2;
            end else if (ifc.done) begin
                adv = 1'b1;
            end else if (v - 1 == TIMEOUT) begin
                tmo_set = 1'b1; adv = 1'b1;
            end else begin
                v++;
            end
            if (adv) begin
                if (ch == NCH - 1) act = 1'b0;
                else begin ch++; v = 0; end
            end
            m_active <= act; m_ch <= ch; m_v <= v;
            if (ifc.cfg_we) m_cfg[ifc.cfg_addr] <= ifc.cfg_wdata;
            if (ovr_set) m_ovr <= 1'b1; else if (ifc.clr_err) m_ovr <= 1'b0;
            if (tmo_set) m_tmo <= 1'b1; else if (ifc.clr_err) m_tmo <= 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en)
            check("cycle_outputs",
                  {ifc.start, ifc.chan, ifc.rate, ifc.law, ifc.dec, ifc.busy, ifc.overrun, ifc.timeout},
                  {(m_active && m_v == 1), m_chan, m_rate, m_law, m_dec, m_active, m_ovr, m_tmo});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input logic [4:0] d);
        ifc.cfg_we = 1'b1; ifc.cfg_addr = 5'(ch); ifc.cfg_wdata = d;
        cyc();
        ifc.cfg_we = 1'b0;
    endtask

    task automatic fs_pulse();
        ifc.fs = 1'b1;
        cyc();
        ifc.fs = 1'b0;
    endtask

    task automatic wait_start(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc();
            if (ifc.start) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int bound, output int n_busy, output int n_start);
        n_busy = 0; n_start = 0;
        for (int i = 0; i < bound; i++) begin
            if (!ifc.busy) return;
            n_busy++;
            if (ifc.start) n_start++;
            cyc();
        end
    endtask

    initial begin
        bit         seen;
        int         nb, ns, n, nst;
        logic [8:0] st_log [4];

        reset = 1'b1;
        ifc.fs = 1'b0; ifc.cfg_we = 1'b0; ifc.cfg_addr = '0; ifc.cfg_wdata = '0;
        ifc.clr_err = 1'b0;
        cyc(); cyc();
        check("reset_state",
              {ifc.start, ifc.chan, ifc.rate, ifc.law, ifc.dec, ifc.busy, ifc.overrun, ifc.timeout}, 13'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Single channel 0, done five cycles after start
        dp_auto = 1'b1; dp_delay = 5;
        cfg_write(0, 5'b10001);
        fs_pulse();
        cyc();
        check("ch0_start", {ifc.start, ifc.chan, ifc.rate, ifc.law, ifc.dec}, {1'b1, 5'd0, 2'd1, 1'b0, 1'b0});
        wait_idle(100, nb, ns);
        check("ch0_frame_busy", nb, 37);
        check("ch0_flags", {ifc.overrun, ifc.timeout}, 2'b00);

        // Two enabled channels at opposite ends of the table
        dp_delay = 3;
        cfg_write(0, 5'b00000);
        cfg_write(3, 5'b11111);
        cfg_write(31, 5'b10000);
        fs_pulse();
        nst = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ifc.busy) break;
            if (ifc.start) begin
                if (nst < 4) st_log[nst] = {ifc.chan, ifc.rate, ifc.law, ifc.dec};
                nst++;
            end
            cyc();
        end
        check("two_starts_count", nst, 2);
        check("two_starts_first", st_log[0], {5'd3, 2'd3, 1'b1, 1'b1});
        check("two_starts_second", st_log[1], {5'd31, 2'd0, 1'b0, 1'b0});

        // Channel 5 never answered: overrun mid-wait, then timeout, then ch6
        cfg_write(3, 5'b00000);
        cfg_write(31, 5'b00000);
        cfg_write(5, 5'b10010);
        cfg_write(6, 5'b10001);
        dp_auto = 1'b0;
        fs_pulse();
        wait_start(40, seen);
        check("ch5_start_seen", seen, 1);
        check("ch5_start", {ifc.chan, ifc.rate}, {5'd5, 2'd2});
        n = 0;
        repeat (10) begin cyc(); n++; end
        ifc.fs = 1'b1; cyc(); n++; ifc.fs = 1'b0;
        check("overrun_set", ifc.overrun, 1);
        check("overrun_hold", {ifc.busy, ifc.chan, ifc.rate}, {1'b1, 5'd5, 2'd2});
        while (!ifc.timeout && n < 400) begin cyc(); n++; end
        check("timeout_after_wait", n, 256);
        check("timeout_busy", ifc.busy, 1);
        dp_auto = 1'b1; dp_delay = 2;
        cyc();
        check("ch6_after_timeout", {ifc.start, ifc.chan, ifc.rate}, {1'b1, 5'd6, 2'd1});
        wait_idle(100, nb, ns);
        check("tmo_frame_ends", ifc.busy, 0);
        ifc.clr_err = 1'b1; cyc(); ifc.clr_err = 1'b0;
        check("clr_err", {ifc.overrun, ifc.timeout}, 2'b00);

        // Config rewrite of the active channel waits for the next frame
        cfg_write(5, 5'b00000);
        cfg_write(6, 5'b00000);
        cfg_write(7, 5'b10000);
        dp_delay = 8;
        fs_pulse();
        wait_start(40, seen);
        check("ch7_start", {seen, ifc.chan, ifc.rate}, {1'b1, 5'd7, 2'd0});
        cyc(); cyc();
        cfg_write(7, 5'b10010);
        check("ch7_rate_held", {ifc.busy, ifc.rate}, {1'b1, 2'd0});
        wait_idle(100, nb, ns);
        fs_pulse();
        wait_start(40, seen);
        check("ch7_rate_new", {seen, ifc.chan, ifc.rate}, {1'b1, 5'd7, 2'd2});
        wait_idle(100, nb, ns);

        // Reset while waiting clears everything
        dp_auto = 1'b0;
        fs_pulse();
        wait_start(40, seen);
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        check("reset_in_wait", {ifc.busy, ifc.start, ifc.chan, ifc.rate, ifc.law, ifc.dec}, 11'd0);
        tb_done = 1'b1; cyc(); tb_done = 1'b0;
        check("late_done_ignored", {ifc.busy, ifc.start}, 2'b00);
        fs_pulse();
        wait_idle(100, nb, ns);
        check("empty_frame_cycles", nb, 32);
        check("empty_frame_starts", ns, 0);

        // Randomized traffic against the model
        dp_auto = 1'b1; dp_rand = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            ifc.cfg_we    = ($urandom % 4 == 0);
            ifc.cfg_addr  = 5'($urandom);
            ifc.cfg_wdata = {($urandom % 2 == 0), 4'($urandom)};
            ifc.fs        = ($urandom % 120 == 0);
            ifc.clr_err   = ($urandom % 60 == 0);
            tb_done       = ($urandom % 25 == 0);
            reset         = ($urandom % 3000 == 0);
            cyc();
        end
        ifc.cfg_we = 1'b0; ifc.fs = 1'b0; ifc.clr_err = 1'b0; tb_done = 1'b0; reset = 1'b0;
        repeat (5) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
